// File: rtl/cpu_defs.sv
// Shared opcode/state definitions and sizing for the mul/div unit.
// No logic of its own, so no latency.
// No handshake of its own, so no backpressure.
package cpu_defs;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    // Opcodes 6 and 7 are reserved: accepted but ignored.
    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_ITER,
        MD_FIX,
        MD_DONE
    } md_state_e;

    // Magnitude of a value taken as negative when 'neg' is set. Two's-complement
    // negation of 0x80000000 yields 0x80000000, which is the correct unsigned
    // magnitude, so the most negative operand needs no special case.
    function automatic logic [WIDTH-1:0] md_mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-to-muldiv request bus plus the HI/LO/status return path.
// Wires only, no latency.
// req_ready is only asserted while the unit is idle.
interface muldiv_sequencer_if;
    import cpu_defs::*;

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Issuing side (EX stage / exception logic).
    modport master (
        output req_valid, req_op, req_a, req_b, cancel,
        input  req_ready, busy, done, hi, lo
    );

    // The mul/div unit.
    modport slave (
        input  req_valid, req_op, req_a, req_b, cancel,
        output req_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_shift_core.sv
// One radix-2 multiply (shift-add) or restoring-divide step per cycle on unsigned magnitudes.
// load initialises in one cycle; 32 steps produce the full 64-bit result.
// No backpressure: the sequencer decides when to load and step.
module muldiv_shift_core
    import cpu_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [CNT_W-1:0]   cnt_o
);

    // Multiply: acc = {partial product, multiplier shifting out}.
    // Divide:   acc = {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor
    logic               div_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;

    // Next accumulator value for a single multiply or divide step.
    always_comb begin
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge    = rem_shift >= {1'b0, opnd_q};
        // When rem_ge holds the true difference is below the divisor, so 32 bits suffice.
        rem_sub   = rem_shift[WIDTH-1:0] - opnd_q;
        acc_d     = acc_q;
        if (div_q) begin
            if (rem_ge) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
            else        acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            if (acc_q[0]) acc_d = {add_sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // Operand load, step advance and iteration count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load_i) begin
            acc_q  <= {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
            opnd_q <= is_div_i ? b_i : a_i;
            div_q  <= is_div_i;
            cnt_q  <= '0;
        end else if (step_i) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign acc_o = acc_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO with the HI/LO register pair.
// done 34 cycles after accept for mul/div, 1 cycle for MTHI/MTLO.
// req_ready only in IDLE; cancel aborts ITER/FIX and blocks an IDLE accept.
module muldiv_sequencer
    import cpu_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    muldiv_sequencer_if.slave  md
);

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Sign/corner bookkeeping captured at accept for the FIX correction.
    logic               div_q;
    logic               neg_q;      // product / quotient must be negated
    logic               a_neg_q;    // remainder takes the dividend's sign
    logic               b_zero_q;
    logic [WIDTH-1:0]   a_q;

    logic               accept;
    logic               op_signed, op_is_div, a_neg, b_neg;
    logic               load, step;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    muldiv_shift_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (op_is_div),
        .a_i      (md_mag(md.req_a, a_neg)),
        .b_i      (md_mag(md.req_b, b_neg)),
        .acc_o    (acc),
        .cnt_o    (cnt)
    );

    // Request decode and FIX-stage sign correction of the raw engine result.
    always_comb begin
        accept    = md.req_valid && (state_q == MD_IDLE) && !md.cancel;
        op_signed = (md.req_op == MD_OP_MULT) || (md.req_op == MD_OP_DIV);
        op_is_div = (md.req_op == MD_OP_DIV)  || (md.req_op == MD_OP_DIVU);
        a_neg     = op_signed && md.req_a[WIDTH-1];
        b_neg     = op_signed && md.req_b[WIDTH-1];
        prod      = neg_q   ? -acc                   : acc;
        quot      = neg_q   ? -acc[WIDTH-1:0]         : acc[WIDTH-1:0];
        rem       = a_neg_q ? -acc[2*WIDTH-1:WIDTH]   : acc[2*WIDTH-1:WIDTH];
    end

    // FSM next state, engine controls and HI/LO write data.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    case (md.req_op)
                        MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                            load    = 1'b1;
                            state_d = MD_ITER;
                        end
                        MD_OP_MTHI: begin
                            hi_d    = md.req_a;
                            state_d = MD_DONE;
                        end
                        MD_OP_MTLO: begin
                            lo_d    = md.req_a;
                            state_d = MD_DONE;
                        end
                        default: ;
                    endcase
                end
            end
            MD_ITER: begin
                if (md.cancel) begin
                    state_d = MD_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                if (md.cancel) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_DONE;
                    if (!div_q) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (b_zero_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State, HI/LO and accept-time bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (load) begin
                div_q    <= op_is_div;
                neg_q    <= a_neg ^ b_neg;
                a_neg_q  <= a_neg;
                b_zero_q <= (md.req_b == '0);
                a_q      <= md.req_a;
            end
        end
    end

    assign md.req_ready = (state_q == MD_IDLE);
    assign md.busy      = (state_q == MD_ITER) || (state_q == MD_FIX);
    assign md.done      = (state_q == MD_DONE);
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

endmodule
